fmac_issue_ctrl: RTL
====================

Name: fmac_issue_ctrl

Overview:
- Issue and sequencing controller for the single-precision fused multiply-add datapath, which ends in the normalize-and-round stage.
- Arbitrates two requesters onto one datapath and drives the datapath's per-stage register enables.
- Tracks each in-flight operation's tag, source and resolved rounding mode until it reaches the rounding stage.
- Returns results through a valid/ready port and accumulates sticky RISC-V fflags.

Parameters:
- PARM_STAGES, 3, datapath pipeline depth; the last stage is normalize/round; legal range 2-8
- PARM_TAG, 5, width of the requester tag
- PARM_RM, 3, rounding-mode field width
- PARM_RM_DYN, 3'b111, instruction rm code meaning "use frm"

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- req0_valid_i  in  1  requester 0 has an op
- req0_ready_o  out  1  requester 0 op accepted this cycle
- req0_rm_i  in  PARM_RM  requester 0 instruction rm
- req0_tag_i  in  PARM_TAG  requester 0 tag
- req1_valid_i / req1_ready_o / req1_rm_i / req1_tag_i  same widths, requester 1
- frm_i  in  PARM_RM  fcsr.frm
- flush_i  in  1  kill all in-flight ops
- dp_sel_o  out  1  operand-mux select for datapath stage 0 (0 = req0, 1 = req1)
- dp_stage_en_o  out  PARM_STAGES  load enable per datapath stage register
- dp_rm_o  out  PARM_RM  resolved rm of the op in the last stage
- dp_flags_i  in  4  {NV,OF,UF,NX} from the rounding stage, combinational, valid while the last stage holds an op
- res_valid_o  out  1  result valid
- res_ready_i  in  1  consumer ready
- res_tag_o  out  PARM_TAG  result tag
- res_src_o  out  1  result source requester
- res_flags_o  out  5  {NV,DZ=0,OF,UF,NX} for this result
- illegal_o  out  1  one-cycle pulse: accepted op had an invalid rm
- illegal_tag_o  out  PARM_TAG  tag of the illegal op
- fflags_o  out  5  accumulated sticky flags
- fflags_clr_i  in  1  clear the accumulated flags
- busy_o  out  1  any stage valid

Behaviour:
- Reset (asynchronous, active-high) clears all of the following to 0: valid bits, per-stage tag/src/rm, the round-robin pointer, fflags_o, illegal_o and illegal_tag_o.
- Registered-output reset values: fflags_o=0, illegal_o=0, illegal_tag_o=0. Combinational outputs settle to 0 from the cleared state: res_valid_o, busy_o, dp_stage_en_o, res_tag_o, res_src_o, dp_rm_o.
- Per-stage state: v[k], tag[k], src[k], rm[k].
- Advance rule: adv[S-1] = ~v[S-1] | res_ready_i; adv[k] = ~v[k] | adv[k+1]. dp_stage_en_o[k] = adv[k].
- Stage k loads from stage k-1 when adv[k]. Stage 0 loads the granted request, or a bubble if there is none.
- Latency: an op accepted in cycle n presents res_valid_o in cycle n+PARM_STAGES when there is no stall. Throughput is 1 op/cycle.
- Arbitration:
  - A request is eligible only when adv[0]=1 and flush_i=0.
  - If both requesters are valid, grant the one the pointer selects. The pointer then flips to the other requester.
  - If only one is valid, grant it; the pointer is set to the other requester.
  - Only the granted requester sees ready_o=1. dp_sel_o = granted index (holds its last value when idle).
- Rounding-mode resolution at grant:
  - If rm = PARM_RM_DYN, use frm_i; otherwise use rm.
  - A resolved value of 5, 6 or 7 is illegal.
  - An illegal op is still handshaken (ready=1) but inserts a bubble into stage 0.
  - Next cycle: illegal_o=1 and illegal_tag_o=tag. No flags are raised for illegal ops.
- Result port:
  - res_valid_o = v[S-1]; res_tag_o/res_src_o from the last stage; dp_rm_o = rm[S-1].
  - res_flags_o = {dp_flags_i[3],1'b0,dp_flags_i[2:0]}.
  - res_valid_o holds stable while res_ready_i=0.
- fflags accumulation: on a result handshake, fflags |= res_flags_o.
  - fflags_clr_i alone clears fflags.
  - clr together with a handshake: fflags = res_flags_o (the new flags survive the clear).
- flush_i:
  - Next cycle all v=0; tag/src/rm contents are don't-care.
  - In the flush cycle: no grant; a last-stage op is not handshaken even if res_ready_i=1, and it accumulates no flags. res_valid_o is forced to 0 in that cycle.
  - illegal_o does not pulse for the flush cycle; fflags are unaffected.
- Flush has priority over the advance/grant logic in the same cycle.
- busy_o = |v.

Decomposition:
- Shared package fmac_pkg holds:
  - rounding-mode constants RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100, DYN=111;
  - fflags bit indices NV=4, DZ=3, OF=2, UF=1, NX=0;
  - a stage-payload struct {tag, src, rm}.
- One sub-module is natural: fmac_rr_arb2 (2-way round-robin arbiter with enable and pointer update). Everything else lives in the top module.

Test Plan:
- Single issue: req0 rm=000, tag=5, res_ready=1 → req0_ready in cycle 0; res_valid with tag=5, src=0, dp_rm_o=000 in cycle 3; busy_o high in cycles 1-3.
- Contention: both requesters valid for 4 cycles, pointer=0 → grants 0,1,0,1; results return in the same order with src 0,1,0,1.
- Backpressure: 3 ops in flight, res_ready=0 for 5 cycles → no readys, dp_stage_en_o=000, outputs stable. Releasing res_ready drains in order with no op lost.
- Dynamic/illegal rm: rm=111 with frm=011 → dp_rm_o=011. rm=101, tag=9 → ready=1, illegal_o pulse with illegal_tag_o=9, no result emitted.
- Flags: results with dp_flags_i=0001 then 0100 → fflags_o=00001, then 00101. fflags_clr_i together with a handshake carrying 1000 → fflags_o=10000.
- Flush: 3 ops in flight, flush_i=1 with res_ready=1 → no result, no flag change; busy_o=0 next cycle; a new request is granted the cycle after the flush.

Source files
------------

// File: rtl/fmac_pkg.sv
// Shared definitions for the FMA issue controller.
// Holds the RISC-V rounding-mode encodings, the fflags bit positions, the
// per-stage payload carried alongside each in-flight operation, and a helper
// that decides whether a resolved rounding mode is usable.
package fmac_pkg;

    // Rounding-mode encodings (instruction rm field / fcsr.frm)
    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;
    localparam logic [2:0] RM_DYN = 3'b111;

    // Bit positions inside the 5-bit fflags vector {NV,DZ,OF,UF,NX}
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    // Default field widths of the stage payload
    localparam int TAG_W = 5;
    localparam int RM_W  = 3;

    // Side-band information that travels down the pipeline with each op
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             src;
        logic [RM_W-1:0]  rm;
    } stage_payload_t;

    // Only the five defined static modes can reach the rounder
    function automatic logic rm_legal(input logic [RM_W-1:0] rm);
        case (rm)
            RM_RNE, RM_RTZ, RM_RDN, RM_RUP, RM_RMM: rm_legal = 1'b1;
            default:                                rm_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fmac_rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   en_i           a grant may be issued this cycle
//   req_i[1:0]     request vector
//   gnt_o[1:0]     one-hot grant (all zero when nothing is granted)
//   gnt_valid_o    a grant is issued this cycle
//   sel_o          granted index, or the last granted index when idle
// The pointer names the requester that wins a tie; after any grant it points
// at the requester that did not win.
module fmac_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output logic       gnt_valid_o,
    output logic       sel_o
);

    logic ptr_q, ptr_d;
    logic sel_q, sel_d;
    logic idx;

    assign idx         = (req_i == 2'b11) ? ptr_q : req_i[1];
    assign gnt_valid_o = en_i & (|req_i);
    assign gnt_o       = gnt_valid_o ? (idx ? 2'b10 : 2'b01) : 2'b00;
    assign sel_o       = gnt_valid_o ? idx : sel_q;

    assign ptr_d = gnt_valid_o ? ~idx : ptr_q;
    assign sel_d = gnt_valid_o ? idx  : sel_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
            sel_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            sel_q <= sel_d;
        end
    end

endmodule

// File: rtl/fmac_issue_ctrl.sv
// Issue and sequencing controller for the single-precision FMA datapath.
// Arbitrates two requesters onto the datapath, drives the per-stage load
// enables, carries tag/source/resolved-rm of each op down the pipe, returns
// results over a valid/ready port and accumulates sticky fflags.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   reqN_valid_i/ready_o         requester handshake (ready = granted)
//   reqN_rm_i, reqN_tag_i        instruction rm and tag of each requester
//   frm_i                        fcsr.frm, used when rm is dynamic
//   flush_i                      kill every in-flight op
//   dp_sel_o                     stage-0 operand mux select
//   dp_stage_en_o                per-stage datapath register load enable
//   dp_rm_o                      resolved rm of the op in the rounding stage
//   dp_flags_i                   {NV,OF,UF,NX} from the rounding stage
//   res_valid_o/res_ready_i      result handshake
//   res_tag_o, res_src_o         identity of the result
//   res_flags_o                  {NV,DZ,OF,UF,NX} of the result
//   illegal_o, illegal_tag_o     pulse + tag for an op with an invalid rm
//   fflags_o, fflags_clr_i       accumulated sticky flags and their clear
//   busy_o                       any stage holds an op
module fmac_issue_ctrl
    import fmac_pkg::*;
#(
    parameter int               PARM_STAGES = 3,
    parameter int               PARM_TAG    = TAG_W,
    parameter int               PARM_RM     = RM_W,
    parameter logic [PARM_RM-1:0] PARM_RM_DYN = RM_DYN
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req0_valid_i,
    output logic                   req0_ready_o,
    input  logic [PARM_RM-1:0]     req0_rm_i,
    input  logic [PARM_TAG-1:0]    req0_tag_i,
    input  logic                   req1_valid_i,
    output logic                   req1_ready_o,
    input  logic [PARM_RM-1:0]     req1_rm_i,
    input  logic [PARM_TAG-1:0]    req1_tag_i,
    input  logic [PARM_RM-1:0]     frm_i,
    input  logic                   flush_i,
    output logic                   dp_sel_o,
    output logic [PARM_STAGES-1:0] dp_stage_en_o,
    output logic [PARM_RM-1:0]     dp_rm_o,
    input  logic [3:0]             dp_flags_i,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [PARM_TAG-1:0]    res_tag_o,
    output logic                   res_src_o,
    output logic [4:0]             res_flags_o,
    output logic                   illegal_o,
    output logic [PARM_TAG-1:0]    illegal_tag_o,
    output logic [4:0]             fflags_o,
    input  logic                   fflags_clr_i,
    output logic                   busy_o
);

    localparam int LAST = PARM_STAGES - 1;

    logic [PARM_STAGES-1:0] v_q, v_d;
    logic [PARM_STAGES-1:0] adv;
    stage_payload_t         pay_q [PARM_STAGES];
    stage_payload_t         pay_d [PARM_STAGES];

    logic [1:0]          gnt;
    logic                gnt_valid;
    logic                grant_en;
    logic [PARM_RM-1:0]  g_rm_raw, g_rm;
    logic [PARM_TAG-1:0] g_tag;
    logic                g_legal;
    stage_payload_t      new_pay;

    logic                res_hs;
    logic [4:0]          fflags_d;
    logic                illegal_d;
    logic [PARM_TAG-1:0] illegal_tag_d;

    // A stage may load when it is empty or when its content moves on
    always_comb begin
        adv       = '0;
        adv[LAST] = ~v_q[LAST] | res_ready_i;
        for (int k = LAST - 1; k >= 0; k--) begin
            adv[k] = ~v_q[k] | adv[k+1];
        end
    end

    // Datapath registers are held while reset is asserted
    assign dp_stage_en_o = rst_i ? '0 : adv;

    assign grant_en = ~rst_i & adv[0] & ~flush_i;

    fmac_rr_arb2 u_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (grant_en),
        .req_i       ({req1_valid_i, req0_valid_i}),
        .gnt_o       (gnt),
        .gnt_valid_o (gnt_valid),
        .sel_o       (dp_sel_o)
    );

    assign req0_ready_o = gnt[0];
    assign req1_ready_o = gnt[1];

    assign g_rm_raw = gnt[1] ? req1_rm_i  : req0_rm_i;
    assign g_tag    = gnt[1] ? req1_tag_i : req0_tag_i;
    assign g_rm     = (g_rm_raw == PARM_RM_DYN) ? frm_i : g_rm_raw;
    assign g_legal  = rm_legal(g_rm);

    assign new_pay = '{tag: g_tag, src: gnt[1], rm: g_rm};

    // Stage 0: granted legal op, otherwise a bubble (illegal ops are
    // consumed but never enter the datapath)
    assign v_d[0]   = flush_i ? 1'b0 : (adv[0] ? (gnt_valid & g_legal) : v_q[0]);
    assign pay_d[0] = adv[0] ? new_pay : pay_q[0];

    genvar gi;
    generate
        for (gi = 1; gi < PARM_STAGES; gi++) begin : g_stage
            assign v_d[gi]   = flush_i ? 1'b0 : (adv[gi] ? v_q[gi-1] : v_q[gi]);
            assign pay_d[gi] = adv[gi] ? pay_q[gi-1] : pay_q[gi];
        end
    endgenerate

    // Result port; the op in the last stage is invisible during a flush
    assign res_valid_o = v_q[LAST] & ~flush_i;
    assign res_tag_o   = pay_q[LAST].tag;
    assign res_src_o   = pay_q[LAST].src;
    assign dp_rm_o     = pay_q[LAST].rm;
    assign res_hs      = res_valid_o & res_ready_i;
    assign busy_o      = |v_q;

    always_comb begin
        res_flags_o          = '0;
        res_flags_o[FLAG_NV] = dp_flags_i[3];
        res_flags_o[FLAG_DZ] = 1'b0;
        res_flags_o[FLAG_OF] = dp_flags_i[2];
        res_flags_o[FLAG_UF] = dp_flags_i[1];
        res_flags_o[FLAG_NX] = dp_flags_i[0];
    end

    // A clear coinciding with a handshake keeps the new result's flags
    always_comb begin
        fflags_d = fflags_o;
        if (res_hs && fflags_clr_i) begin
            fflags_d = res_flags_o;
        end else if (res_hs) begin
            fflags_d = fflags_o | res_flags_o;
        end else if (fflags_clr_i) begin
            fflags_d = '0;
        end
    end

    assign illegal_d     = gnt_valid & ~g_legal;
    assign illegal_tag_d = illegal_d ? g_tag : illegal_tag_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v_q           <= '0;
            for (int k = 0; k < PARM_STAGES; k++) begin
                pay_q[k] <= '0;
            end
            fflags_o      <= '0;
            illegal_o     <= 1'b0;
            illegal_tag_o <= '0;
        end else begin
            v_q           <= v_d;
            pay_q         <= pay_d;
            fflags_o      <= fflags_d;
            illegal_o     <= illegal_d;
            illegal_tag_o <= illegal_tag_d;
        end
    end

endmodule
